// File: rtl/network_scheduler_pkg.sv
// Shared constants and types for the network scheduler and the network rule logic.
// Defaults describe the 38-rule network; rules 17 and 18 have registered outputs.
package network_scheduler_pkg;

  localparam int DEF_STATE_W   = 32;
  localparam int DEF_RULE_W    = 6;
  localparam int DEF_NUM_RULES = 38;
  localparam int ROUND_W       = 10;

  localparam logic [DEF_NUM_RULES-1:0] DEF_REG_RULE_MASK = 38'h0_0006_0000;

  // x^16 + x^14 + x^13 + x^11 + 1, as bit positions 15/13/12/10
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_REG,
    ROUND_END,
    FINISH
  } sched_state_t;

endpackage

// File: rtl/network_scheduler_rule_lfsr.sv
// 16-bit Fibonacci LFSR used to pick random rule indices; steps once per enabled cycle.
// No backpressure: the value simply holds while en is low.
module rule_lfsr
  import network_scheduler_pkg::*;
#(
  parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= SEED;
    end else if (en) begin
      value <= {value[14:0], ^(value & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/network_scheduler.sv
// Owns the network state register and steps it through rounds of rule updates, one rule per step.
// 1 cycle per combinational rule, 2 per registered rule, plus 1 per round end; start is ignored while busy.
module network_scheduler
  import network_scheduler_pkg::*;
#(
  parameter int                    STATE_W       = DEF_STATE_W,
  parameter int                    RULE_W        = DEF_RULE_W,
  parameter int                    NUM_RULES     = DEF_NUM_RULES,
  parameter logic [NUM_RULES-1:0]  REG_RULE_MASK = DEF_REG_RULE_MASK,
  parameter bit                    RANDOM_ORDER  = 1'b0,
  parameter logic [15:0]           LFSR_SEED     = DEF_LFSR_SEED
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [STATE_W-1:0]  init_state,
  input  logic [ROUND_W-1:0]  num_rounds,
  output logic [RULE_W-1:0]   rule,
  output logic [ROUND_W-1:0]  round_number,
  output logic [STATE_W-1:0]  current_state,
  input  logic [STATE_W-1:0]  next_state,
  output logic [STATE_W-1:0]  round_state,
  output logic                round_valid,
  output logic                busy,
  output logic                done
);

  sched_state_t        st;
  logic [RULE_W-1:0]   step;
  logic [RULE_W-1:0]   held_rule;
  logic [ROUND_W-1:0]  rounds_q;
  logic [15:0]         lfsr;
  logic [RULE_W-1:0]   cand;
  logic                cand_ok;
  logic                cand_reg;
  logic                last_step;
  logic                unused_lfsr_hi;

  rule_lfsr #(.SEED(LFSR_SEED)) u_rule_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (RANDOM_ORDER && (st == ISSUE)),
    .value (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:RULE_W];

  // Random draws outside 0..NUM_RULES-1 are rejected and cost one idle cycle.
  assign cand      = RANDOM_ORDER ? lfsr[RULE_W-1:0] : step;
  assign cand_ok   = 32'(cand) < NUM_RULES;
  assign cand_reg  = cand_ok && REG_RULE_MASK[cand];
  assign last_step = 32'(step) == (NUM_RULES - 1);

  always_comb begin
    rule = '0;
    if (st == ISSUE && cand_ok) begin
      rule = cand;
    end else if (st == WAIT_REG) begin
      rule = held_rule;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st            <= IDLE;
      step          <= '0;
      held_rule     <= '0;
      rounds_q      <= '0;
      round_number  <= '0;
      current_state <= '0;
      round_state   <= '0;
      round_valid   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      round_valid <= 1'b0;
      done        <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            current_state <= init_state;
            round_number  <= '0;
            step          <= '0;
            rounds_q      <= num_rounds;
            busy          <= 1'b1;
            st            <= (num_rounds == '0) ? FINISH : ISSUE;
          end
        end
        ISSUE: begin
          if (cand_ok) begin
            if (cand_reg) begin
              held_rule <= cand;
              st        <= WAIT_REG;
            end else begin
              current_state <= next_state;
              step          <= step + RULE_W'(1);
              if (last_step) st <= ROUND_END;
            end
          end
        end
        WAIT_REG: begin
          current_state <= next_state;
          step          <= step + RULE_W'(1);
          st            <= last_step ? ROUND_END : ISSUE;
        end
        ROUND_END: begin
          round_state <= current_state;
          round_valid <= 1'b1;
          step        <= '0;
          if (round_number != '1) round_number <= round_number + ROUND_W'(1);
          st <= ((round_number + ROUND_W'(1)) == rounds_q) ? FINISH : ISSUE;
        end
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/network_scheduler.md
Name: network_scheduler

Overview:
- Drives the rule-based network update logic from the other end of its interface.
- Owns the network state register and issues one rule index per update step.
- Supplies current_state and round_number, then captures next_state back into the register.
- Runs a requested number of rounds in sequential or random-asynchronous order, and publishes the state at the end of every round.

Parameters:
- STATE_W, `STATE: width of the packed network state vector.
- RULE_W, `LOG_RULES: width of the rule index.
- NUM_RULES, 38: rule indices 0..NUM_RULES-1 are valid.
- REG_RULE_MASK, 38'h0_0006_0000 (rules 17, 18): set bit means the rule's logic has a registered output and needs one extra cycle.
- RANDOM_ORDER, 0: 0 = sequential rule order, 1 = LFSR random order with replacement.
- LFSR_SEED, 16'hACE1: reset value of the 16-bit LFSR; must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- init_state  in  STATE_W  state loaded on an accepted start
- num_rounds  in  10  rounds to run; 0 means finish immediately
- rule  out  RULE_W  rule index presented to the network logic
- round_number  out  10  current round, 0-based
- current_state  out  STATE_W  state register contents
- next_state  in  STATE_W  network logic result
- round_state  out  STATE_W  state snapshot at round end
- round_valid  out  1  one-cycle pulse when round_state is updated
- busy  out  1  high from accepted start until DONE
- done  out  1  one-cycle pulse when the run completes

Behaviour:
- Reset is asynchronous, active-high. All outputs and registers go to 0, except the LFSR, which goes to LFSR_SEED. FSM enters IDLE.
- FSM states: IDLE, ISSUE, WAIT_REG, ROUND_END, FINISH.
- IDLE:
  - On start: state register <= init_state, round <= 0, step <= 0, busy <= 1.
  - Next state is ISSUE, or FINISH if num_rounds == 0.
  - num_rounds is latched on start.
  - start in any non-IDLE state is ignored.
- Rule selection (ISSUE):
  - Sequential mode: rule = step.
  - Random mode: rule = LFSR[RULE_W-1:0]. If that value is >= NUM_RULES, the LFSR advances and the cycle is spent without an update (rejection). It retries next cycle and step does not advance.
- Combinational rule (mask bit clear):
  - Present rule for 1 cycle; state register <= next_state at the end of that cycle.
  - Latency: 1 cycle per step.
- Registered rule (mask bit set):
  - ISSUE presents the rule, with no capture, then moves to WAIT_REG.
  - WAIT_REG holds rule and current_state unchanged for a second cycle and captures next_state at its end.
  - Latency: 2 cycles per step.
- After each capture:
  - step increments.
  - If step reaches NUM_RULES-1 at capture, go to ROUND_END; otherwise stay in ISSUE.
- A round is exactly NUM_RULES captured steps in both modes. Random mode samples with replacement.
- ROUND_END (1 cycle):
  - round_state <= state register; round_valid pulses.
  - step <= 0 and round increments.
  - If the new round equals the latched num_rounds, go to FINISH; otherwise go to ISSUE.
- round_number reflects the round in progress. It is stable for the whole round, including during ROUND_END.
- FINISH: done pulses for 1 cycle, busy <= 0, go to IDLE. The state register holds the final state.
- The LFSR advances once per ISSUE cycle in random mode only. Its polynomial is x^16+x^14+x^13+x^11+1.
- The round counter saturates at 1023; it never wraps within a run because num_rounds <= 1023.
- When not issuing (IDLE, ROUND_END, FINISH), rule drives 0, and next_state is never captured.
- Reset asserted mid-run aborts immediately: no round_valid or done pulse, and the LFSR is reseeded.

Decomposition:
- Shared package holds:
  - the FSM state enum;
  - the LFSR tap constant and default seed;
  - the NUM_RULES constant;
  - the registered-rule mask constant, shared with the network logic definitions.
- One sub-module: rule_lfsr. It is a 16-bit Fibonacci LFSR with enable and asynchronous reset, and exposes its value.

Test Plan:
- Sequential, num_rounds=1, network logic stubbed as next_state = current_state+1: round_valid after 38+2=40 step cycles; round_state = init+38; done 1 cycle after ROUND_END.
- Rule 17 in sequential mode: rule held at 17 for exactly 2 cycles; capture only at the end of the second cycle; current_state constant across both.
- num_rounds=0 with start: busy pulses, done pulses 1 cycle after FINISH; no round_valid; state register = init_state.
- Random mode, seed 16'hACE1, num_rounds=3: exactly 38 captures per round; every rule value < 38; rule sequence matches the golden LFSR model including rejection cycles.
- rst asserted at step 20 of round 2: all outputs 0 on the same edge; no done; a fresh start reruns from round 0 with the same random sequence.
- start pulsed while busy: ignored; num_rounds and state unchanged; run completes normally.
